// File: rtl/id_scoreboard_if.sv
// ID-stage bundle: IF->ID handshake, operand sources, retire port and ID->EX handshake.
// The master modport drives the ID stage; the slave modport is the ID stage itself.
interface id_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NSRC = 3
);
  localparam int RW = $clog2(NREG);

  logic                   in_valid;
  logic                   in_ready;
  logic [RW-1:0]          in_rs1;
  logic [RW-1:0]          in_rs2;
  logic [RW-1:0]          in_rd;
  logic                   in_rd1_en;
  logic                   in_rd2_en;
  logic                   in_rf_we;
  logic                   in_long_lat;
  logic [XLEN-1:0]        rf_rd1;
  logic [XLEN-1:0]        rf_rd2;
  logic [NSRC-1:0]        fwd_valid;
  logic [NSRC-1:0]        fwd_we;
  logic [NSRC-1:0]        fwd_data_ok;
  logic [NSRC*RW-1:0]     fwd_reg;
  logic [NSRC*XLEN-1:0]   fwd_data;
  logic                   retire_valid;
  logic [RW-1:0]          retire_reg;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_rs1_data;
  logic [XLEN-1:0]        out_rs2_data;
  logic [RW-1:0]          out_rd;
  logic                   out_rf_we;
  logic                   out_long_lat;
  logic [31:0]            stall_cnt;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd1_en, in_rd2_en, in_rf_we, in_long_lat,
    output rf_rd1, rf_rd2, fwd_valid, fwd_we, fwd_data_ok, fwd_reg, fwd_data,
    output retire_valid, retire_reg, flush, out_ready,
    input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rf_we, out_long_lat,
    input  stall_cnt
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd1_en, in_rd2_en, in_rf_we, in_long_lat,
    input  rf_rd1, rf_rd2, fwd_valid, fwd_we, fwd_data_ok, fwd_reg, fwd_data,
    input  retire_valid, retire_reg, flush, out_ready,
    output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rf_we, out_long_lat,
    output stall_cnt
  );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage hazard/bypass block: one ID slot, priority bypass over NSRC producers, stall on
// unproduced operands. Define ID_SCOREBOARD_EN to build the in-flight scoreboard and retire port.
module id_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NSRC  = 3,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst_n,
  id_scoreboard_if.slave  bus
);
  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic            hit;
    logic            ok;
    logic [XLEN-1:0] data;
  } byp_t;

  // Descending scan so the lowest-index (youngest) matching source is the last writer and wins.
  function automatic byp_t resolve(
    input logic [RW-1:0]        rs,
    input logic [NSRC-1:0]      v,
    input logic [NSRC-1:0]      we,
    input logic [NSRC-1:0]      ok,
    input logic [NSRC*RW-1:0]   regs,
    input logic [NSRC*XLEN-1:0] data
  );
    byp_t r;
    r = '0;
    for (int j = NSRC - 1; j >= 0; j--) begin
      if (v[j] && we[j] && regs[j*RW +: RW] != '0 && regs[j*RW +: RW] == rs) begin
        r.hit  = 1'b1;
        r.ok   = ok[j];
        r.data = data[j*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  logic          id_valid_q, id_valid_d;
  logic [RW-1:0] id_rs1_q, id_rs2_q, id_rd_q;
  logic          id_rd1_en_q, id_rd2_en_q, id_rf_we_q, id_long_lat_q;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  byp_t byp1, byp2;
  logic sb_busy1, sb_busy2, sat_hz;
  logic hz1, hz2, ready_go;
  logic in_ready, out_valid, handshake, slot_load;

  assign byp1 = resolve(id_rs1_q, bus.fwd_valid, bus.fwd_we, bus.fwd_data_ok,
                        bus.fwd_reg, bus.fwd_data);
  assign byp2 = resolve(id_rs2_q, bus.fwd_valid, bus.fwd_we, bus.fwd_data_ok,
                        bus.fwd_reg, bus.fwd_data);

  assign hz1 = id_valid_q && id_rd1_en_q && (byp1.hit ? !byp1.ok : sb_busy1);
  assign hz2 = id_valid_q && id_rd2_en_q && (byp2.hit ? !byp2.ok : sb_busy2);
  assign ready_go = !(hz1 || hz2 || sat_hz);

  assign out_valid = id_valid_q && ready_go;
  assign in_ready  = !id_valid_q || (ready_go && bus.out_ready);
  assign handshake = out_valid && bus.out_ready;
  assign slot_load = !bus.flush && bus.in_valid && in_ready;

`ifdef ID_SCOREBOARD_EN
  logic [CNT_W-1:0] sb_cnt_q [NREG];
  logic [CNT_W-1:0] sb_cnt_d [NREG];
  logic             sb_inc, sb_dec, sb_same;

  assign sb_inc  = handshake && id_rf_we_q && id_long_lat_q && id_rd_q != '0;
  assign sb_dec  = bus.retire_valid && bus.retire_reg != '0;
  assign sb_same = sb_inc && sb_dec && bus.retire_reg == id_rd_q;

  assign sb_busy1 = sb_cnt_q[id_rs1_q] != '0;
  assign sb_busy2 = sb_cnt_q[id_rs2_q] != '0;
  assign sat_hz   = id_valid_q && id_rf_we_q && id_long_lat_q && (sb_cnt_q[id_rd_q] == '1);

  // Increment and decrement of one register in the same cycle cancel out.
  always_comb begin
    sb_cnt_d = sb_cnt_q;
    if (sb_inc && !sb_same) begin
      sb_cnt_d[id_rd_q] = sb_cnt_q[id_rd_q] + CNT_W'(1);
    end
    if (sb_dec && !sb_same && sb_cnt_q[bus.retire_reg] != '0) begin
      sb_cnt_d[bus.retire_reg] = sb_cnt_q[bus.retire_reg] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        sb_cnt_q[r] <= '0;
      end
    end else begin
      sb_cnt_q <= sb_cnt_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = ^{bus.retire_valid, bus.retire_reg};
  assign sb_busy1 = 1'b0;
  assign sb_busy2 = 1'b0;
  assign sat_hz   = 1'b0;
`endif

  always_comb begin
    id_valid_d = id_valid_q;
    if (bus.flush) begin
      id_valid_d = 1'b0;
    end else if (in_ready) begin
      id_valid_d = bus.in_valid;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid_q && !ready_go && !bus.flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_q    <= 1'b0;
      id_rs1_q      <= '0;
      id_rs2_q      <= '0;
      id_rd_q       <= '0;
      id_rd1_en_q   <= 1'b0;
      id_rd2_en_q   <= 1'b0;
      id_rf_we_q    <= 1'b0;
      id_long_lat_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (slot_load) begin
        id_rs1_q      <= bus.in_rs1;
        id_rs2_q      <= bus.in_rs2;
        id_rd_q       <= bus.in_rd;
        id_rd1_en_q   <= bus.in_rd1_en;
        id_rd2_en_q   <= bus.in_rd2_en;
        id_rf_we_q    <= bus.in_rf_we;
        id_long_lat_q <= bus.in_long_lat;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_rs1_data = (id_rs1_q == '0) ? '0 : (byp1.hit ? byp1.data : bus.rf_rd1);
  assign bus.out_rs2_data = (id_rs2_q == '0) ? '0 : (byp2.hit ? byp2.data : bus.rf_rd2);
  assign bus.out_rd       = id_rd_q;
  assign bus.out_rf_we    = id_rf_we_q;
  assign bus.out_long_lat = id_long_lat_q;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios then random traffic, checked against a
// cycle-level reference model through an expectation queue drained by a monitor.
module tb_id_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NSRC  = 3;
  localparam int CNT_W = 2;
  localparam int RW    = $clog2(NREG);
  localparam int SB_MAX = (1 << CNT_W) - 1;
`ifdef ID_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  id_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC)) bif ();

  id_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [RW-1:0]   rd;
    logic            we;
    logic            ll;
    logic [31:0]     stall;
  } exp_t;

  exp_t          expq[$];
  logic [RW-1:0] inflight[$];
  int checks = 0;
  int errors = 0;

  // Reference state: the held instruction, per-register in-flight counts, stall counter.
  bit            m_valid;
  logic [RW-1:0] m_rs1, m_rs2, m_rd;
  bit            m_e1, m_e2, m_we, m_ll;
  int            m_sb[NREG];
  logic [31:0]   m_stall;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_e1 = 0; m_e2 = 0; m_we = 0; m_ll = 0;
    for (int r = 0; r < NREG; r++) m_sb[r] = 0;
    m_stall = '0;
    inflight.delete();
  endtask

  // Operand value and readiness: youngest matching producer, else register file gated by the
  // in-flight count; x0 is always zero and always ready.
  function automatic void m_operand(input logic [RW-1:0] rs, input logic [XLEN-1:0] rf,
                                    output logic [XLEN-1:0] val, output bit ok);
    val = rf;
    ok  = 1'b1;
    if (rs == 0) begin
      val = '0;
      return;
    end
    for (int j = 0; j < NSRC; j++) begin
      if (bif.fwd_valid[j] && bif.fwd_we[j] && bif.fwd_reg[j*RW +: RW] == rs) begin
        val = bif.fwd_data[j*XLEN +: XLEN];
        ok  = bif.fwd_data_ok[j];
        return;
      end
    end
    ok = !SB_EN || (m_sb[rs] == 0);
  endfunction

  task automatic step();
    exp_t e;
    logic [XLEN-1:0] v1, v2;
    bit ok1, ok2, go, sat, ovalid, iready, inc, dec;
    m_operand(m_rs1, bif.rf_rd1, v1, ok1);
    m_operand(m_rs2, bif.rf_rd2, v2, ok2);
    sat = SB_EN && m_valid && m_we && m_ll && (m_sb[m_rd] == SB_MAX);
    go  = !((m_valid && m_e1 && !ok1) || (m_valid && m_e2 && !ok2) || sat);
    ovalid = m_valid && go;
    iready = !m_valid || (go && bif.out_ready);
    e.in_ready = iready; e.out_valid = ovalid; e.d1 = v1; e.d2 = v2;
    e.rd = m_rd; e.we = m_we; e.ll = m_ll; e.stall = m_stall;
    expq.push_back(e);
    if (!rst_n) begin
      m_reset();
      return;
    end
    inc = ovalid && bif.out_ready && m_we && m_ll && m_rd != 0;
    dec = bif.retire_valid && bif.retire_reg != 0;
    if (inc) inflight.push_back(m_rd);
    if (SB_EN && !(inc && dec && m_rd == bif.retire_reg)) begin
      if (inc) m_sb[m_rd]++;
      if (dec && m_sb[bif.retire_reg] > 0) m_sb[bif.retire_reg]--;
    end
    if (m_valid && !go && !bif.flush) m_stall++;
    if (bif.flush) m_valid = 0;
    else if (iready) begin
      m_valid = bif.in_valid;
      if (bif.in_valid) begin
        m_rs1 = bif.in_rs1; m_rs2 = bif.in_rs2; m_rd = bif.in_rd;
        m_e1 = bif.in_rd1_en; m_e2 = bif.in_rd2_en;
        m_we = bif.in_rf_we; m_ll = bif.in_long_lat;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp("in_ready", 32'(bif.in_ready), 32'(e.in_ready));
        cmp("out_valid", 32'(bif.out_valid), 32'(e.out_valid));
        cmp("stall_cnt", bif.stall_cnt, e.stall);
        if (e.out_valid) begin
          cmp("out_rs1_data", bif.out_rs1_data, e.d1);
          cmp("out_rs2_data", bif.out_rs2_data, e.d2);
          cmp("out_rd", 32'(bif.out_rd), 32'(e.rd));
          cmp("out_rf_we", 32'(bif.out_rf_we), 32'(e.we));
          cmp("out_long_lat", 32'(bif.out_long_lat), 32'(e.ll));
        end
      end
    end
  end

  task automatic idle();
    rst_n = 1'b1;
    bif.in_valid = 0; bif.in_rs1 = '0; bif.in_rs2 = '0; bif.in_rd = '0;
    bif.in_rd1_en = 0; bif.in_rd2_en = 0; bif.in_rf_we = 0; bif.in_long_lat = 0;
    bif.rf_rd1 = '0; bif.rf_rd2 = '0;
    bif.fwd_valid = '0; bif.fwd_we = '0; bif.fwd_data_ok = '1;
    bif.fwd_reg = '0; bif.fwd_data = '0;
    bif.retire_valid = 0; bif.retire_reg = '0;
    bif.flush = 0; bif.out_ready = 1;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input int rs1, input bit e1, input int rs2, input bit e2,
                       input int rd, input bit we, input bit ll);
    bif.in_valid = 1; bif.in_rs1 = RW'(rs1); bif.in_rd1_en = e1;
    bif.in_rs2 = RW'(rs2); bif.in_rd2_en = e2; bif.in_rd = RW'(rd);
    bif.in_rf_we = we; bif.in_long_lat = ll;
  endtask

  task automatic set_src(input int j, input int r, input logic [XLEN-1:0] d, input bit ok);
    bif.fwd_valid[j] = 1'b1;
    bif.fwd_we[j] = 1'b1;
    bif.fwd_reg[j*RW +: RW] = RW'(r);
    bif.fwd_data[j*XLEN +: XLEN] = d;
    bif.fwd_data_ok[j] = ok;
  endtask

  initial begin
    rst_n = 1'b0;
    bif.in_valid = 0; bif.flush = 0; bif.out_ready = 1;
    bif.retire_valid = 0; bif.retire_reg = '0;
    bif.fwd_valid = '0; bif.fwd_we = '0; bif.fwd_data_ok = '1;
    bif.fwd_reg = '0; bif.fwd_data = '0;
    bif.in_rs1 = '0; bif.in_rs2 = '0; bif.in_rd = '0;
    bif.in_rd1_en = 0; bif.in_rd2_en = 0; bif.in_rf_we = 0; bif.in_long_lat = 0;
    bif.rf_rd1 = '0; bif.rf_rd2 = '0;
    m_reset();
    repeat (2) @(posedge clk);

    // EX beats MEM on x5
    nxt(); issue(5, 1, 0, 0, 1, 1, 0); step();
    nxt(); set_src(0, 5, 32'h1234, 1); set_src(1, 5, 32'hFFFF, 1); step();
    #2; cmp("s1_valid", 32'(bif.out_valid), 1); cmp("s1_rs1", bif.out_rs1_data, 32'h1234);

    // load-use on x7: one stall, then MEM forwards
    nxt(); issue(0, 0, 7, 1, 2, 1, 0); step();
    nxt(); set_src(0, 7, 32'hDEAD, 0); step();
    #2; cmp("s2_stall", 32'(bif.out_valid), 0);
    nxt(); set_src(1, 7, 32'hABCD, 1); step();
    #2; cmp("s2_valid", 32'(bif.out_valid), 1); cmp("s2_rs2", bif.out_rs2_data, 32'hABCD);
    cmp("s2_stall_cnt", bif.stall_cnt, 1);

    // x0 source with fwd_reg=0 and data not ready
    nxt(); issue(0, 1, 0, 0, 3, 0, 0); step();
    nxt(); set_src(0, 0, 32'h5555, 0); step();
    #2; cmp("x0_valid", 32'(bif.out_valid), 1); cmp("x0_data", bif.out_rs1_data, 0);

    // flush during a stall
    nxt(); issue(7, 1, 0, 0, 4, 1, 0); step();
    nxt(); set_src(0, 7, '0, 0); step();
    nxt(); set_src(0, 7, '0, 0); bif.flush = 1; step();
    nxt(); step();
    #2; cmp("flush_valid", 32'(bif.out_valid), 0); cmp("flush_ready", 32'(bif.in_ready), 1);
    cmp("flush_stall_cnt", bif.stall_cnt, 2);

`ifdef ID_SCOREBOARD_EN
    // long-latency x9 then dependent read after it left the bypass network
    nxt(); issue(0, 0, 0, 0, 9, 1, 1); step();
    nxt(); step();
    nxt(); issue(9, 1, 0, 0, 10, 0, 0); step();
    nxt(); step(); #2; cmp("sb_stall_a", 32'(bif.out_valid), 0);
    nxt(); step(); #2; cmp("sb_stall_b", 32'(bif.out_valid), 0);
    nxt(); bif.retire_valid = 1; bif.retire_reg = 5'd9; step();
    #2; cmp("sb_stall_c", 32'(bif.out_valid), 0);
    nxt(); step(); #2; cmp("sb_release", 32'(bif.out_valid), 1);

    // saturation on x3
    for (int k = 0; k < 3; k++) begin
      nxt(); issue(0, 0, 0, 0, 3, 1, 1); step();
      nxt(); step();
    end
    nxt(); issue(0, 0, 0, 0, 3, 1, 1); step();
    nxt(); step(); #2; cmp("sat_stall", 32'(bif.out_valid), 0);
    nxt(); bif.retire_valid = 1; bif.retire_reg = 5'd3; step();
    #2; cmp("sat_stall_retire", 32'(bif.out_valid), 0);
    nxt(); step(); #2; cmp("sat_release", 32'(bif.out_valid), 1);
`endif

    // reset while stalled
    nxt(); issue(7, 1, 0, 0, 4, 1, 0); step();
    nxt(); set_src(0, 7, '0, 0); step();
    nxt(); set_src(0, 7, '0, 0); rst_n = 1'b0; step();
    nxt(); step();
    #2; cmp("rst_valid", 32'(bif.out_valid), 0); cmp("rst_ready", 32'(bif.in_ready), 1);
    cmp("rst_stall_cnt", bif.stall_cnt, 0);

    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst_n = ($urandom_range(0, 299) != 0);
      bif.in_valid = ($urandom_range(0, 3) != 0);
      bif.in_rs1 = RW'($urandom_range(0, 7));
      bif.in_rs2 = RW'($urandom_range(0, 7));
      bif.in_rd  = RW'($urandom_range(0, 7));
      bif.in_rd1_en = 1'($urandom_range(0, 1));
      bif.in_rd2_en = 1'($urandom_range(0, 1));
      bif.in_rf_we = 1'($urandom_range(0, 1));
      bif.in_long_lat = ($urandom_range(0, 2) == 0);
      bif.rf_rd1 = $urandom;
      bif.rf_rd2 = $urandom;
      for (int j = 0; j < NSRC; j++) begin
        bif.fwd_valid[j] = ($urandom_range(0, 9) < 7);
        bif.fwd_we[j] = ($urandom_range(0, 9) < 7);
        bif.fwd_reg[j*RW +: RW] = RW'($urandom_range(0, 7));
        bif.fwd_data[j*XLEN +: XLEN] = $urandom;
        bif.fwd_data_ok[j] = ($urandom_range(0, 4) != 0);
      end
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        bif.retire_valid = 1;
        bif.retire_reg = inflight.pop_front();
      end else if ($urandom_range(0, 15) == 0) begin
        bif.retire_valid = 1;
        bif.retire_reg = RW'($urandom_range(0, 7));
      end
      bif.flush = ($urandom_range(0, 19) == 0);
      bif.out_ready = ($urandom_range(0, 4) != 0);
      step();
    end

    nxt();
    repeat (2) @(negedge clk);
    #3;
    cmp("queue_drained", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised decode-stage hazard and bypass block, the successor to the fixed three-source load-use detector in the ID stage. It holds one decoded instruction in an ID pipeline slot, resolves source operands through a priority bypass network of `NSRC` producer stages, and stalls on operands not yet produced. A per-register in-flight scoreboard covers variable-latency writers (loads, multi-cycle ALU ops) that are no longer visible on any bypass source. It sits between the IF→ID register and EX, replacing the hard-wired `ex/mem/wb` forwarding muxes.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, architectural registers; register 0 is hard-wired zero
- `NSRC`, 3, bypass sources; index 0 is youngest (EX), `NSRC-1` oldest (WB)
- `CNT_W`, 2, width of each scoreboard in-flight counter
- `clk` in 1, the single clock
- `rst_n` in 1, reset; synchronous, active-low
- `in_valid` in 1, IF has an instruction for ID
- `in_ready` out 1, ID accepts this cycle (`id_allow_in`)
- `in_rs1`, `in_rs2`, `in_rd` in clog2(NREG) each, register indices
- `in_rd1_en`, `in_rd2_en` in 1 each, operand used
- `in_rf_we` in 1, instruction writes `in_rd`
- `in_long_lat` in 1, result is not produced in EX
- `rf_rd1`, `rf_rd2` in XLEN each, raw register-file read data for the held instruction
- `fwd_valid`, `fwd_we`, `fwd_data_ok` in NSRC each, per-source valid, write-enable, data-ready
- `fwd_reg` in NSRC·clog2(NREG), packed destinations
- `fwd_data` in NSRC·XLEN, packed data
- `retire_valid` in 1, long-latency result written to RF
- `retire_reg` in clog2(NREG), its register
- `flush` in 1, branch cancel of the ID slot
- `out_valid` out 1, ID→EX valid
- `out_ready` in 1, EX allow-in
- `out_rs1_data`, `out_rs2_data` out XLEN each, final operands
- `out_rd`, `out_rf_we`, `out_long_lat` out, registered copies of the held fields
- `stall_cnt` out 32, performance count of stall cycles

## Operation
- ID slot: `id_valid` plus the registered `in_*` fields. Load when `in_valid && in_ready`.
- `in_ready = !id_valid || (ready_go && out_ready)`.
- `out_valid = id_valid && ready_go`.
- Slot update priority: `!rst_n` > `flush` (clears `id_valid`) > `in_ready` (`id_valid <= in_valid`).
- Source `j` matches `rsX` when `fwd_valid[j] && fwd_we[j] && fwd_reg[j] != 0 && fwd_reg[j] == rsX`.
- Bypass selection: the lowest-index matching source wins and drives its `fwd_data`. With no match, `rf_rdX` is used. `rsX == 0` always yields 0.
- Per-operand hazard, evaluated only when `id_valid && in_rdX_en`:
  - the winning source has `fwd_data_ok == 0`; or
  - there is no match and `sb_cnt[rsX] != 0`.
- `ready_go = !(hz1 || hz2 || sat_hz)`.
- `sat_hz` is 1 when the held instruction is a long-latency writer and `sb_cnt[rd] == 2^CNT_W-1`. It prevents counter overflow.
- Scoreboard increment: a handshake (`out_valid && out_ready`) with `out_rf_we && out_long_lat && out_rd != 0`.
- Scoreboard decrement: `retire_valid && retire_reg != 0`.
- Simultaneous increment and decrement on the same register leaves the count unchanged. A decrement at 0 holds 0.
- `flush` does not touch the scoreboard, because instructions past ID are not cancelled.
- `stall_cnt` increments each cycle `id_valid && !ready_go && !flush`. It wraps at 2^32.

## Timing
- Reset values: `id_valid=0`, all `sb_cnt=0`, `stall_cnt=0`, `out_valid=0`, and all registered fields 0. With `out_valid=0`, `in_ready=1` the first cycle after reset.
- Paths from bypass inputs, `rf_rd*` and `out_ready` to `out_*_data`, `ready_go` and `in_ready` are combinational, with zero added latency.
- Scoreboard and `stall_cnt` update on `posedge clk`; a change is visible to hazard logic the next cycle.
- Same-cycle retire and read of one register: the WB bypass match forwards the data, so no stall occurs.
- Reset asserted mid-stall: the slot empties and the scoreboard clears on that edge.

## Configuration
- `ID_SCOREBOARD_EN` defined:
  - scoreboard, `sat_hz` and the `retire_*` logic are built.
- Undefined:
  - `sb_cnt` is absent, and both the scoreboard hazard term and `sat_hz` are treated as 0.
  - `retire_*` are ignored.
  - Hazards come only from `fwd_data_ok == 0`. This equals the legacy EX-load-use behaviour when `fwd_data_ok[0] = !ex_is_load`.

## Test plan
- EX source writes x5=0x1234 with `data_ok=1`, MEM source writes x5=0xFFFF, ID reads x5 → `out_rs1_data=0x1234`, no stall.
- EX load to x7 (`data_ok=0`), ID uses x7 as rs2 → exactly 1 stall cycle and `stall_cnt=1`; next cycle MEM forwards 0xABCD → `out_rs2_data=0xABCD`.
- Long-latency write to x9 issued, then dependent read after x9 has left all bypass sources → stall until `retire_valid`/`retire_reg=9` → `sb_cnt[9]` returns to 0 and the dependent issues the cycle after.
- Three long-latency writes to x3 with `CNT_W=2` → the fourth stalls on `sat_hz` until one retire.
- `flush` during a stall → `out_valid=0` the next cycle, `sb_cnt` unchanged, `in_ready=1`.
- rs1=x0 while an EX source has `fwd_reg=0`, `data_ok=0` → `out_rs1_data=0`, no stall.
